// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI receive deserializer, MSB first, valid/ready word output with frame_err/overrun flags.
// Define SPI_RX_SYNC_EN to add 2-flop input synchronizers for an asynchronous master.
module spi_rx_deser #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_l,
    input  logic              spi_clk,
    input  logic              spi_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  bit_count,
    output logic              frame_err,
    output logic              overrun
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_d;
    logic s_cs, s_clk, s_data, sclk_q, rise;
    logic shift_en, clr_cnt, err_d, done, load;
    logic [DATA_W-1:0] sreg;
`ifdef SPI_RX_SYNC_EN
    logic [1:0] cs_s, clk_s, data_s;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cs_s <= 2'b11;
            clk_s <= 2'b00;
            data_s <= 2'b00;
        end else begin
            cs_s <= {cs_s[0], spi_cs_l};
            clk_s <= {clk_s[0], spi_clk};
            data_s <= {data_s[0], spi_data};
        end
    assign s_cs = cs_s[1];
    assign s_clk = clk_s[1];
    assign s_data = data_s[1];
`else
    assign s_cs = spi_cs_l;
    assign s_clk = spi_clk;
    assign s_data = spi_data;
`endif
    assign rise = s_clk & ~sclk_q;
    // A completed word is dropped only when the previous one is still pending and not being taken.
    assign load = done & ~(out_valid & ~out_ready);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        shift_en = 1'b0;
        clr_cnt = 1'b0;
        err_d = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt = 1'b1;
                state_d = s_cs ? IDLE : SHIFT;
            end
            SHIFT:
                if (s_cs) begin
                    state_d = IDLE;
                    clr_cnt = 1'b1;
                    err_d = bit_count != '0;
                end else if (rise) begin
                    shift_en = 1'b1;
                    state_d = (bit_count == CNT_W'(DATA_W - 1)) ? DONE : SHIFT;
                end
            DONE: begin
                done = 1'b1;
                clr_cnt = 1'b1;
                state_d = s_cs ? IDLE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sreg <= '0;
            bit_count <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= s_clk;
            frame_err <= err_d;
            if (shift_en) begin
                sreg <= {sreg[DATA_W-2:0], s_data};
                bit_count <= bit_count + CNT_W'(1);
            end else if (clr_cnt) begin
                bit_count <= '0;
            end
            if (load) begin
                out_data <= sreg;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (done && out_valid && !out_ready) overrun <= 1'b1;
        end
endmodule

// File: doc/spi_rx_deser.md
Name: spi_rx_deser

Overview:
- Downstream receive stage for the team's SPI bit-serial master link.
- Samples spi_cs_l, spi_clk and spi_data in the system clock domain, detects spi_clk rising edges and shifts in DATA_W bits MSB first.
- Presents each completed word on a valid/ready output port.
- Flags incomplete frames and words lost to back-pressure.

Parameters:
DATA_W, 16, word width in bits; also the number of spi_clk rising edges per frame.
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  system clock; also the clock of the upstream serializer.
rst  input  1  asynchronous, active-high reset.
spi_cs_l  input  1  frame select, active low.
spi_clk  input  1  serial clock; data is sampled on its rising edge.
spi_data  input  1  serial data, MSB first.
out_data  output  DATA_W  last completed word.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high on a clk edge.
bit_count  output  CNT_W  bits received in the current frame, 0..DATA_W.
frame_err  output  1  one-cycle pulse: spi_cs_l rose with bit_count not equal to 0 and not equal to DATA_W.
overrun  output  1  sticky flag: a word completed while out_valid=1 and out_ready=0.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: shift register 0, bit_count 0, out_data 0, out_valid 0, frame_err 0, overrun 0, sclk_q 0.
- Inputs used directly unless SPI_RX_SYNC_EN is defined (see Optional Feature).
- Edge detect: sclk_q registers the sampled spi_clk every cycle. rise = spi_clk & ~sclk_q.
- State machine, 3 states:
  - IDLE: spi_cs_l=1. bit_count held at 0. Go to SHIFT when spi_cs_l=0.
  - SHIFT: on rise with spi_cs_l=0:
    - shift left, new LSB = spi_data;
    - bit_count += 1;
    - if bit_count becomes DATA_W, go to DONE.
  - SHIFT, spi_cs_l=1: go to IDLE and clear bit_count. Pulse frame_err for one cycle if bit_count was 1..DATA_W-1.
  - DONE: lasts one cycle.
    - Load out_data from the shift register and set out_valid=1.
    - If out_valid was already 1 and out_ready=0 that cycle: keep old out_data, drop the new word, set overrun=1.
    - Clear bit_count to 0 and return to SHIFT if spi_cs_l=0, otherwise to IDLE. Back-to-back frames without a cs_l gap are allowed.
- Latency: out_valid rises on the clk edge one cycle after the clk edge that captured the DATA_W-th bit.
- Handshake:
  - out_valid falls on the edge where out_valid and out_ready are both 1, unless DONE loads a new word on that same edge. Simultaneous accept and load counts as a load: out_valid stays 1, out_data updates, no overrun.
  - out_data is stable while out_valid=1 and not accepted.
- A rise while spi_cs_l=1 is ignored.
- A rise on the same cycle that spi_cs_l rises is ignored; the cs_l rule takes priority.
- overrun clears only on rst.
- frame_err when cs_l rises with bit_count = DATA_W: cannot occur, because DONE already cleared bit_count.
- Upstream timing is 2 clk per bit, data stable before the rise, and a 1-cycle cs_l-high gap between words. The block must decode this with no lost bits.
- rst mid-frame: partial word discarded, all outputs return to reset values immediately.

Optional Feature:
- Macro: SPI_RX_SYNC_EN.
- Defined:
  - spi_cs_l, spi_clk and spi_data each pass through a 2-flop synchronizer on clk before any other use.
  - Synchronizer reset values: cs_l 1, clk 0, data 0.
  - Adds 2 cycles to every latency above.
  - For use when the master runs on an unrelated clock. Requires spi_clk high and low times of at least 3 clk each.
- Not defined: inputs are used directly, no extra latency.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs -> out_valid=0, out_data=0x0000, bit_count=0, overrun=0, frame_err=0.
- Single frame: drive 0xA5C3 MSB first at 2 clk/bit with cs_l low, out_ready=1 -> out_valid pulses 1 cycle after the 16th rise, out_data=0xA5C3, bit_count back to 0.
- Back-to-back words: frames 0x1234 and 0xFFFF with a 1-cycle cs_l gap, out_ready=1 -> both words delivered in order, overrun=0, frame_err=0.
- Short frame: 7 bits then cs_l high -> frame_err high exactly 1 cycle, no out_valid; next full frame 0x0001 received correctly.
- Back-pressure:
  - Hold out_ready=0 across words 0xBEEF and 0x0F0F -> out_data stays 0xBEEF, overrun=1.
  - Then raise out_ready -> out_valid drops after 1 cycle.
- Reset mid-frame: rst after 9 bits, then a full frame 0x8001 -> out_data=0x8001, no frame_err. Repeat all scenarios with SPI_RX_SYNC_EN defined and expect +2-cycle latency.
